// File: rtl/sfp_link_pkg.sv
// Shared definitions for the SFP video link: header layout, default marker
// and idle pattern, and the framer state encoding.
package sfp_link_pkg;

   localparam int HDR_MAGIC_LSB = 48;
   localparam int HDR_MAGIC_W   = 16;
   localparam int HDR_CH_LSB    = 44;
   localparam int HDR_CH_W      = 4;
   localparam int HDR_SOF_BIT   = 43;
   localparam int HDR_SEQ_LSB   = 16;
   localparam int HDR_SEQ_W     = 16;
   localparam int HDR_LEN_LSB   = 0;
   localparam int HDR_LEN_W     = 16;

   localparam logic [15:0] DEF_MAGIC     = 16'hA55A;
   localparam logic [63:0] DEF_IDLE_WORD = 64'h0707070707070707;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY
   } frm_state_t;

   function automatic logic [63:0] build_header(
      input logic [HDR_MAGIC_W-1:0] magic,
      input logic [HDR_CH_W-1:0]    ch_id,
      input logic                   sof,
      input logic [HDR_SEQ_W-1:0]   seq,
      input logic [HDR_LEN_W-1:0]   len
   );
      logic [63:0] hdr;
      hdr = '0;
      hdr[HDR_MAGIC_LSB +: HDR_MAGIC_W] = magic;
      hdr[HDR_CH_LSB +: HDR_CH_W]       = ch_id;
      hdr[HDR_SOF_BIT]                  = sof;
      hdr[HDR_SEQ_LSB +: HDR_SEQ_W]     = seq;
      hdr[HDR_LEN_LSB +: HDR_LEN_W]     = len;
      return hdr;
   endfunction

endpackage

// File: rtl/sfp_sync_fifo.sv
// Synchronous first-word-fall-through FIFO: rd_data always shows the head
// entry while not empty, so a read can be issued in the same cycle it is seen.
module sfp_sync_fifo #(
   parameter int  WIDTH = 65,
   parameter int  DEPTH = 512,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    rd_addr_next;
   logic [AW:0]      level_reg;
   logic             do_wr;
   logic             do_rd;

   assign full         = (level_reg == (AW+1)'(DEPTH));
   assign empty        = (level_reg == '0);
   assign do_wr        = wr_en && !full;
   assign do_rd        = rd_en && !empty;
   assign rd_addr_next = rd_ptr_reg + AW'(do_rd);

   // Read the address the head will occupy next cycle; forward a word being
   // written to that same address so a write into an empty FIFO falls through.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
      if (do_wr && (wr_ptr_reg == rd_addr_next)) begin
         rd_data_reg <= wr_data;
      end else begin
         rd_data_reg <= mem[rd_addr_next];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         rd_ptr_reg <= rd_addr_next;
         case ({do_wr, do_rd})
            2'b10:   level_reg <= level_reg + (AW+1)'(1);
            2'b01:   level_reg <= level_reg - (AW+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign rd_data = rd_data_reg;
   assign level   = level_reg;

endmodule

// File: rtl/sfp_video_framer.sv
// Cuts a buffered video word stream into header-prefixed fixed-length packets
// for the SFP transmit interface, with overflow counting and sof-based resync.
module sfp_video_framer
   import sfp_link_pkg::*;
#(
   parameter int          DATA_W     = 64,
   parameter int          FIFO_DEPTH = 512,
   parameter int          PKT_WORDS  = 256,
   parameter logic [3:0]  CH_ID      = 4'd0,
   parameter logic [15:0] MAGIC      = DEF_MAGIC,
   parameter bit          IDLE_EN    = 1'b1,
   parameter logic [63:0] IDLE_WORD  = DEF_IDLE_WORD,
   localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sof,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ctrl,
   output logic              out_sof,
   output logic [LVL_W-1:0]  fifo_level,
   output logic [15:0]       ovf_cnt,
   output logic              resync
);

   localparam logic [LVL_W-1:0] PKT_LVL   = LVL_W'(PKT_WORDS);
   localparam logic [15:0]      PKT_LEN   = 16'(PKT_WORDS);
   localparam logic [15:0]      LAST_BEAT = 16'(PKT_WORDS - 1);

   logic [1:0]        rst_pipe_reg;
   logic              rst_n_int;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W:0]   fifo_rd_data;
   logic [LVL_W-1:0]  fifo_lvl;
   logic              wr_accept;
   logic              wr_drop;
   logic              rd_en;
   logic              resync_reg;
   logic              resync_next;
   logic [15:0]       ovf_cnt_reg;
   logic [15:0]       ovf_cnt_next;
   frm_state_t        state_reg;
   frm_state_t        state_next;
   logic [15:0]       pkt_seq_reg;
   logic [15:0]       beat_cnt_reg;
   logic [15:0]       beat_cnt_next;
   logic              seq_inc;
   logic              valid_c;
   logic              ctrl_c;
   logic              sof_c;
   logic [DATA_W-1:0] data_c;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_pipe_reg <= 2'b00;
      end else begin
         rst_pipe_reg <= {rst_pipe_reg[0], 1'b1};
      end
   end
   assign rst_n_int = rst_pipe_reg[1];

   sfp_sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (sys_clk),
      .rst_n   (rst_n_int),
      .wr_en   (wr_accept),
      .wr_data ({in_sof, in_data}),
      .rd_en   (rd_en),
      .rd_data (fifo_rd_data),
      .level   (fifo_lvl),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // After an overflow, only a frame start can re-open the input.
   always_comb begin
      wr_accept    = in_valid && !fifo_full && (!resync_reg || in_sof);
      wr_drop      = in_valid && !wr_accept;
      resync_next  = wr_drop ? 1'b1 : (wr_accept ? 1'b0 : resync_reg);
      ovf_cnt_next = (wr_drop && (ovf_cnt_reg != 16'hFFFF)) ? ovf_cnt_reg + 16'd1 : ovf_cnt_reg;
   end

   always_comb begin
      state_next    = state_reg;
      beat_cnt_next = beat_cnt_reg;
      seq_inc       = 1'b0;
      rd_en         = 1'b0;
      valid_c       = 1'b0;
      ctrl_c        = 1'b0;
      sof_c         = 1'b0;
      data_c        = '0;
      case (state_reg)
         IDLE: begin
            if (IDLE_EN) begin
               valid_c      = 1'b1;
               ctrl_c       = 1'b1;
               data_c[63:0] = IDLE_WORD;
            end
            if ((fifo_lvl >= PKT_LVL) && (!IDLE_EN || out_ready)) begin
               state_next = HDR;
            end
         end
         HDR: begin
            valid_c      = 1'b1;
            ctrl_c       = 1'b1;
            data_c[63:0] = build_header(MAGIC, CH_ID, fifo_rd_data[DATA_W], pkt_seq_reg, PKT_LEN);
            if (out_ready) begin
               state_next    = PAY;
               beat_cnt_next = '0;
            end
         end
         PAY: begin
            valid_c = !fifo_empty;
            sof_c   = fifo_rd_data[DATA_W];
            data_c  = fifo_rd_data[DATA_W-1:0];
            if (out_ready && !fifo_empty) begin
               rd_en = 1'b1;
               if (beat_cnt_reg == LAST_BEAT) begin
                  seq_inc       = 1'b1;
                  beat_cnt_next = '0;
                  // Level still counts the word leaving now, hence strictly greater.
                  state_next    = (fifo_lvl > PKT_LVL) ? HDR : IDLE;
               end else begin
                  beat_cnt_next = beat_cnt_reg + 16'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_reg    <= IDLE;
         beat_cnt_reg <= '0;
         pkt_seq_reg  <= '0;
         resync_reg   <= 1'b0;
         ovf_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         beat_cnt_reg <= beat_cnt_next;
         resync_reg   <= resync_next;
         ovf_cnt_reg  <= ovf_cnt_next;
         if (seq_inc) begin
            pkt_seq_reg <= pkt_seq_reg + 16'd1;
         end
      end
   end

   assign out_valid  = valid_c && rst_n_int;
   assign out_ctrl   = ctrl_c && rst_n_int;
   assign out_sof    = sof_c && rst_n_int;
   assign out_data   = rst_n_int ? data_c : '0;
   assign fifo_level = fifo_lvl;
   assign ovf_cnt    = ovf_cnt_reg;
   assign resync     = resync_reg;

endmodule

// File: tb/tb_sfp_video_framer.sv
// Self-checking bench for sfp_video_framer: table-driven packets plus
// overflow, sequence-wrap and mid-packet reset sequences, checked by a scoreboard.
module tb_sfp_video_framer;

   localparam int          DW     = 64;
   localparam int          DEPTH  = 8;
   localparam int          PW     = 4;
   localparam logic [63:0] IDLE_W = 64'h0707070707070707;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        in_valid  = 1'b0;
   logic [63:0] in_data   = '0;
   logic        in_sof    = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [63:0] out_data;
   logic        out_ctrl;
   logic        out_sof;
   logic [3:0]  fifo_level;
   logic [15:0] ovf_cnt;
   logic        resync;

   sfp_video_framer #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .PKT_WORDS  (PW)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sof     (in_sof),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ctrl   (out_ctrl),
      .out_sof    (out_sof),
      .fifo_level (fifo_level),
      .ovf_cnt    (ovf_cnt),
      .resync     (resync)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic        ctrl;
      logic        sof;
      logic [63:0] data;
   } beat_t;

   typedef struct {
      logic [63:0] base;
      logic [3:0]  sof_mask;
      bit          stall;
      logic [63:0] exp_hdr;
   } vec_t;

   beat_t       exp_q[$];
   beat_t       pend_q[$];
   beat_t       held;
   logic        held_v    = 1'b0;
   logic        mon_en    = 1'b0;
   int          n_checks  = 0;
   int          n_pass    = 0;
   int          pay_seen  = 0;
   logic [15:0] model_seq = '0;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [63:0] hdr(input logic sof, input logic [15:0] seq);
      return {16'hA55A, 4'h0, sof, 11'h000, seq, 16'd4};
   endfunction

   // Scoreboard consumer: every transferred non-idle word must match the queue head.
   always @(negedge sys_clk) begin
      beat_t cur;
      cur = {out_ctrl, out_sof, out_data};
      if (!mon_en) begin
         held_v = 1'b0;
      end else begin
         if (held_v) check("hold", 72'({out_valid, cur}), 72'({1'b1, held}));
         if (out_valid && out_ready) begin
            if (out_ctrl && out_data == IDLE_W) begin
               check("idle_sof", 72'(out_sof), 72'(0));
            end else if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_beat: got %h expected none", cur);
            end else begin
               check(out_ctrl ? "header" : "payload", 72'(cur), 72'(exp_q.pop_front()));
               if (!out_ctrl) pay_seen++;
            end
         end
         held_v = out_valid && !out_ready;
         held   = cur;
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = s;
      tick();
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // Drive one word; accepted words feed the packet model.
   task automatic send(input logic [63:0] d, input logic s, input bit acc);
      drive(d, s);
      if (acc) begin
         pend_q.push_back({1'b0, s, d});
         if (pend_q.size() == PW) begin
            exp_q.push_back({1'b1, 1'b0, hdr(pend_q[0].sof, model_seq)});
            model_seq++;
            foreach (pend_q[k]) exp_q.push_back(pend_q[k]);
            pend_q.delete();
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         tick();
         k++;
      end
      check({name, "_drain"}, 72'(exp_q.size()), 72'(0));
      repeat (3) tick();
      check({name, "_level"}, 72'(fifo_level), 72'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[4];
      int   k;
      tbl[0] = '{base: 64'h1,  sof_mask: 4'b0001, stall: 1'b0, exp_hdr: 64'hA55A_0800_0000_0004};
      tbl[1] = '{base: 64'h10, sof_mask: 4'b0000, stall: 1'b1, exp_hdr: 64'hA55A_0000_0001_0004};
      tbl[2] = '{base: 64'h20, sof_mask: 4'b0100, stall: 1'b0, exp_hdr: 64'hA55A_0000_0002_0004};
      tbl[3] = '{base: 64'h30, sof_mask: 4'b1001, stall: 1'b0, exp_hdr: 64'hA55A_0800_0003_0004};

      // Reset state
      repeat (2) tick();
      check("rst_valid", 72'(out_valid), 72'(0));
      check("rst_data", 72'(out_data), 72'(0));
      check("rst_level", 72'(fifo_level), 72'(0));
      check("rst_ovf", 72'(ovf_cnt), 72'(0));
      check("rst_resync", 72'(resync), 72'(0));

      // Idle output
      sys_rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         check("idle_word", 72'({out_valid, out_ctrl, out_data}), 72'({1'b1, 1'b1, IDLE_W}));
      end
      check("idle_ovf", 72'(ovf_cnt), 72'(0));
      tick();
      mon_en = 1'b1;

      // Table-driven packets, one with backpressure on payload word 2
      for (int v = 0; v < 4; v++) begin
         exp_q.push_back({1'b1, 1'b0, tbl[v].exp_hdr});
         for (int w = 0; w < PW; w++)
            exp_q.push_back({1'b0, tbl[v].sof_mask[w], tbl[v].base + 64'(w)});
         for (int w = 0; w < PW; w++) drive(tbl[v].base + 64'(w), tbl[v].sof_mask[w]);
         model_seq++;
         if (tbl[v].stall) begin
            k = 0;
            do begin
               @(negedge sys_clk);
               k++;
            end while (!(out_valid && out_ready && !out_ctrl && out_data == tbl[v].base) && k < 50);
            check("stall_seen", 72'(k < 50), 72'(1));
            tick();
            out_ready = 1'b0;
            repeat (5) tick();
            out_ready = 1'b1;
         end
         wait_drain("table");
      end

      // Overflow and resync
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(64'h100 + 64'(i), i == 0, i < DEPTH);
      check("ovf_after10", 72'({ovf_cnt, resync, fifo_level}), 72'({16'd2, 1'b1, 4'd8}));
      for (int i = 0; i < 3; i++) send(64'h200 + 64'(i), 1'b0, 1'b0);
      check("ovf_after13", 72'({ovf_cnt, resync}), 72'({16'd5, 1'b1}));
      send(64'h300, 1'b1, 1'b0);
      check("ovf_sof_full", 72'({ovf_cnt, resync}), 72'({16'd6, 1'b1}));
      out_ready = 1'b1;
      repeat (14) tick();
      send(64'h400, 1'b1, 1'b1);
      check("resync_clear", 72'({ovf_cnt, resync}), 72'({16'd6, 1'b0}));
      for (int i = 1; i < PW; i++) send(64'h400 + 64'(i), 1'b0, 1'b1);
      wait_drain("ovf");

      // Sequence wrap
      dut.pkt_seq_reg = 16'hFFFF;
      model_seq = 16'hFFFF;
      for (int i = 0; i < 2 * PW; i++) send(64'h500 + 64'(i), i == 0, 1'b1);
      wait_drain("wrap");

      // Reset mid-packet
      for (int i = 0; i < PW; i++) send(64'h600 + 64'(i), i == 0, 1'b1);
      k = pay_seen + 2;
      for (int i = 0; i < 50 && pay_seen < k; i++) @(negedge sys_clk);
      check("midpkt_seen", 72'(pay_seen >= k), 72'(1));
      tick();
      mon_en = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      check("midrst_out", 72'({out_valid, out_ctrl, out_sof, out_data}), 72'(0));
      check("midrst_state", 72'({fifo_level, ovf_cnt, resync}), 72'(0));
      exp_q.delete();
      pend_q.delete();
      model_seq = '0;
      repeat (3) tick();
      sys_rst_n = 1'b1;
      repeat (4) tick();
      check("postrst_level", 72'(fifo_level), 72'(0));
      mon_en = 1'b1;
      for (int i = 0; i < PW; i++) send(64'h700 + 64'(i), i == 1, 1'b1);
      wait_drain("postrst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
